// File: rtl/sync_updown_counter_pkg.sv
// Shared types and defaults for the up/down counter slice.
// Imported by the counter interface, core and top.
package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } count_mode_e;

  localparam int COUNTER_WIDTH_DEFAULT = 8;
  localparam int SYNC_STAGES_DEFAULT   = 2;

endpackage

// File: rtl/sync_updown_counter_if.sv
// Control/data bundle between the counter top and its core.
// master drives controls and config, slave returns count and tc.
interface sync_updown_counter_if
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH_DEFAULT
);

  logic             pause;
  logic             dir;
  logic             load;
  logic             mode;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] limit_lo;
  logic [WIDTH-1:0] limit_hi;
  logic [WIDTH-1:0] parallel_in;
  logic [WIDTH-1:0] counter_out;
  logic             tc;

  modport master (
    output pause, dir, load, mode,
    output step, limit_lo, limit_hi, parallel_in,
    input  counter_out, tc
  );

  modport slave (
    input  pause, dir, load, mode,
    input  step, limit_lo, limit_hi, parallel_in,
    output counter_out, tc
  );

endinterface

// File: rtl/sync_updown_counter_core.sv
// Counter datapath: load > pause > count, with wrap or saturate
// at programmable bounds and a registered terminal-count flag.
module sync_updown_counter_core
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
  input logic                  clk,
  input logic                  rst,
  sync_updown_counter_if.slave bus
);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;

  logic [WIDTH:0]   w_up;
  logic [WIDTH:0]   w_dn;
  logic             w_cross_up;
  logic             w_cross_dn;
  logic             w_cross;
  logic             w_enable;
  logic             w_sat;
  logic [WIDTH-1:0] w_bound;

  assign w_up = {1'b0, r_count} + {1'b0, bus.step};
  assign w_dn = {1'b0, r_count} - {1'b0, bus.step};

  // a borrow out of the subtract means we went below zero
  assign w_cross_up = w_up > {1'b0, bus.limit_hi};
  assign w_cross_dn = w_dn[WIDTH] | (w_dn < {1'b0, bus.limit_lo});
  assign w_cross    = bus.dir ? w_cross_up : w_cross_dn;

  assign w_enable = (bus.step != '0) &&
                    (bus.limit_lo <= bus.limit_hi);
  assign w_sat    = count_mode_e'(bus.mode) == CNT_SAT;

  // wrap jumps to the far bound, saturate clamps to the near one
  assign w_bound = (bus.dir ^ w_sat) ? bus.limit_lo
                                     : bus.limit_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else if (bus.load) begin
      r_count <= bus.parallel_in;
      r_tc    <= 1'b0;
    end else if (bus.pause || !w_enable) begin
      r_tc    <= 1'b0;
    end else if (w_cross) begin
      r_count <= w_bound;
      r_tc    <= 1'b1;
    end else begin
      r_count <= bus.dir ? w_up[WIDTH-1:0]
                         : w_dn[WIDTH-1:0];
      r_tc    <= 1'b0;
    end
  end

  assign bus.counter_out = r_count;
  assign bus.tc          = r_tc;

endmodule

// File: rtl/sync_updown_counter_sync_ff.sv
// Multi-flop synchroniser for one asynchronous control bit.
// Async active-high reset clears every stage to 0.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/sync_updown_counter.sv
// Up/down counter top; define SYNC_CTRL_EN to pass pause/dir/load
// through SYNC_STAGES-deep synchronisers, else they are used raw.
module sync_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH       = COUNTER_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pause,
  input  logic             dir,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit_lo,
  input  logic [WIDTH-1:0] limit_hi,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] counter_out,
  output logic             tc
);

  logic w_pause;
  logic w_dir;
  logic w_load;

  if (WIDTH < 2 || WIDTH > 32 || SYNC_STAGES < 2) begin : g_bad_cfg
    $error("sync_updown_counter: bad WIDTH or SYNC_STAGES");
  end

`ifdef SYNC_CTRL_EN
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_pause (
    .clk (clk),
    .rst (reset),
    .i_d (pause),
    .o_q (w_pause)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_dir (
    .clk (clk),
    .rst (reset),
    .i_d (dir),
    .o_q (w_dir)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_load (
    .clk (clk),
    .rst (reset),
    .i_d (load),
    .o_q (w_load)
  );
`else
  assign w_pause = pause;
  assign w_dir   = dir;
  assign w_load  = load;
`endif

  sync_updown_counter_if #(.WIDTH(WIDTH)) u_if ();

  assign u_if.pause       = w_pause;
  assign u_if.dir         = w_dir;
  assign u_if.load        = w_load;
  assign u_if.mode        = mode;
  assign u_if.step        = step;
  assign u_if.limit_lo    = limit_lo;
  assign u_if.limit_hi    = limit_hi;
  assign u_if.parallel_in = parallel_in;

  sync_updown_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk (clk),
    .rst (reset),
    .bus (u_if.slave)
  );

  assign counter_out = u_if.counter_out;
  assign tc          = u_if.tc;

endmodule
